weight_stream_prefetch_buffer: RTL
==================================

Name: weight_stream_prefetch_buffer

Overview:
- Sits between a generated parameter ROM (fixed read latency, ce always high) and the downstream linear/matmul stage.
- Issues ROM row reads and tracks in-flight reads by credit, so the FIFO never overflows.
- Buffers returned rows in a small FIFO and presents them with a true valid/ready handshake.
- Marks the last row of each pass.

Parameters:
- PRECISION, 16, bits per weight lane.
- LANES, 8, weights per ROM row.
- DATA_WIDTH, PRECISION*LANES, ROM row width.
- OUT_DEPTH, 576, rows per pass (ROM MEM_SIZE).
- ADDR_WIDTH, $clog2(OUT_DEPTH)+1, ROM address width.
- ROM_LATENCY, 2, ROM read latency in edges; must be >=1.
- FIFO_DEPTH, 4, buffer entries; must be >=1. FIFO_DEPTH >= ROM_LATENCY+1 is required for 1 row/cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- rom_addr  out  ADDR_WIDTH  ROM read address.
- rom_ce  out  1  ROM clock enable; tied 1.
- rom_q  in  DATA_WIDTH  ROM read data.
- data_out  out  PRECISION x LANES (unpacked [LANES-1:0])  row lanes; lane j = rom_q[PRECISION*j +: PRECISION].
- data_out_valid  out  1  head row valid.
- data_out_ready  in  1  consumer accepts.
- data_out_last  out  1  head row is row OUT_DEPTH-1.
- done  out  1  one-shot pass complete; see Optional Feature.

Behaviour:
- Reset (async assert, any time): rom_addr=0, tag pipeline cleared, FIFO emptied, data_out_valid=0, data_out_last=0, done=0.
  - In-flight reads are discarded, with no stale push after release.
  - data_out resets to 0.
- Credit and issue:
  - inflight = popcount(tag pipeline); occ = FIFO occupancy.
  - issue = (occ + inflight < FIFO_DEPTH) and not stopped; combinational.
  - Count occ after the same-cycle pop, so a pop frees a credit in the same cycle.
- On issue at an edge:
  - tag[0] <= 1, with last-tag = (rom_addr == OUT_DEPTH-1).
  - rom_addr <= (rom_addr == OUT_DEPTH-1) ? 0 : rom_addr+1.
  - Otherwise tag[0] <= 0.
- Tag shift: tag[i] <= tag[i-1] every edge; rom_ce=1, so the ROM pipeline always advances.
- Push: at an edge where tag[ROM_LATENCY-1]=1, rom_q and its last-tag are written to the FIFO tail.
- Pop: at an edge where data_out_valid && data_out_ready.
  - Push and pop in the same edge is legal; occupancy is unchanged.
  - A push into a full FIFO cannot occur; the bench asserts this.
- Outputs: data_out_valid = FIFO not empty; data_out and data_out_last come from the FIFO head. All are registered or direct from FIFO storage; none depend combinationally on data_out_ready.
- Latency: first issue at the 1st edge after reset release; data_out_valid first rises after edge ROM_LATENCY+1 (3 by default).
- Throughput: with ready held 1 and FIFO_DEPTH >= ROM_LATENCY+1, one row per cycle, no bubbles.
- Backpressure: with ready held 0, issue stops once occ+inflight reaches FIFO_DEPTH.
  - The FIFO then fills to exactly FIFO_DEPTH; no row is lost or duplicated.
  - data_out holds stable while valid && !ready.
- Wrap: the row after row OUT_DEPTH-1 is row 0; data_out_last=1 only on row OUT_DEPTH-1.
- OUT_DEPTH=1: every row is last; the address stays 0.

Optional Feature:
- Macro WEIGHT_PREFETCH_ONESHOT_EN.
- Defined:
  - After issuing row OUT_DEPTH-1 the block sets a sticky stopped flag and issues no more reads.
  - done rises the cycle after the last-flagged row is popped and stays 1 until rst.
  - Exactly OUT_DEPTH rows are delivered.
- Undefined: passes repeat forever; done is tied 0.

Test Plan:
- OUT_DEPTH=4, ROM row i = {LANES{16'(i+1)}}, ready=1 from reset:
  - valid rises after edge 3.
  - Stream is 1,2,3,4,1,2,... on consecutive cycles.
  - last=1 on each value-4 row.
  - lane j of each row equals rom_q slice j.
- Hold ready=0 for 20 cycles, then 1:
  - FIFO holds exactly 4 rows (1..4); data_out is stable at 1.
  - Stream resumes with 1,2,3,4,1, with no gaps or duplicates.
- Random ready (50%) over 1000 accepts: the accepted sequence equals (k mod 4)+1, and no FIFO overflow assertion fires.
- Assert rst while 2 reads are in flight and 3 rows are buffered:
  - valid=0 immediately.
  - After release, the first accepted row is 1.
- With WEIGHT_PREFETCH_ONESHOT_EN and ready=1:
  - exactly 4 rows are accepted;
  - done=1 the cycle after row 4 is accepted;
  - rom_addr stops at 0 after wrapping;
  - valid stays 0 thereafter.
- FIFO_DEPTH=2, ROM_LATENCY=2, ready=1: the stream shows periodic bubbles (2 rows per 3 cycles), with data order intact.

Source files
------------

// File: rtl/weight_stream_prefetch_buffer_if.sv
// weight_stream_prefetch_buffer_if: ROM read port plus row stream handshake of the prefetch buffer
interface weight_stream_prefetch_buffer_if #(
    parameter int PRECISION  = 16,
    parameter int LANES      = 8,
    parameter int ADDR_WIDTH = 11
);
    logic [ADDR_WIDTH-1:0]      rom_addr;
    logic                       rom_ce;
    logic [PRECISION*LANES-1:0] rom_q;
    logic [PRECISION-1:0]       data_out [LANES-1:0];
    logic                       data_out_valid;
    logic                       data_out_ready;
    logic                       data_out_last;
    logic                       done;
    modport master (
        output rom_addr, rom_ce, data_out, data_out_valid, data_out_last, done,
        input  rom_q, data_out_ready
    );
    modport slave (
        input  rom_addr, rom_ce, data_out, data_out_valid, data_out_last, done,
        output rom_q, data_out_ready
    );
endinterface

// File: rtl/weight_stream_prefetch_buffer.sv
// weight_stream_prefetch_buffer: credit-tracked ROM row prefetch into a small FIFO with valid/ready output.
// WEIGHT_PREFETCH_ONESHOT_EN stops issuing after one pass and raises a sticky done.
module weight_stream_prefetch_buffer #(
    parameter int PRECISION   = 16,
    parameter int LANES       = 8,
    parameter int DATA_WIDTH  = PRECISION * LANES,
    parameter int OUT_DEPTH   = 576,
    parameter int ADDR_WIDTH  = $clog2(OUT_DEPTH) + 1,
    parameter int ROM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input logic clk,
    input logic rst,
    weight_stream_prefetch_buffer_if.master bus
);
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + ROM_LATENCY + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(OUT_DEPTH - 1);

    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [ROM_LATENCY-1:0] tag_q, tlast_q;
    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  mlast_q;
    logic [PW-1:0]          rd_q, wr_q;
    logic [CW-1:0]          count_q, inflight, credit;
    logic                   valid, issue, push, pop, at_last, stop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // occupancy is taken after this cycle's pop so a pop frees a credit immediately
    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LATENCY; i++) inflight = inflight + CW'(tag_q[i]);
        credit = count_q - CW'(pop) + inflight;
    end

    assign valid   = count_q != '0;
    assign pop     = valid && bus.data_out_ready;
    assign push    = tag_q[ROM_LATENCY-1];
    assign at_last = addr_q == LAST_ADDR;
    assign issue   = (credit < CW'(FIFO_DEPTH)) && !stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            tag_q   <= '0;
            tlast_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            mlast_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            tag_q   <= (tag_q << 1) | ROM_LATENCY'(issue);
            tlast_q <= (tlast_q << 1) | ROM_LATENCY'(issue && at_last);
            if (issue) addr_q <= at_last ? '0 : addr_q + 1'b1;
            if (push) begin
                mem_q[wr_q]   <= bus.rom_q;
                mlast_q[wr_q] <= tlast_q[ROM_LATENCY-1];
                wr_q          <= inc(wr_q);
            end
            if (pop) rd_q <= inc(rd_q);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

`ifdef WEIGHT_PREFETCH_ONESHOT_EN
    logic stop_q, done_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stop_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            stop_q <= stop_q | (issue & at_last);
            done_q <= done_q | (pop & mlast_q[rd_q]);
        end
    end
    assign stop     = stop_q;
    assign bus.done = done_q;
`else
    assign stop     = 1'b0;
    assign bus.done = 1'b0;
`endif

    assign bus.rom_addr       = addr_q;
    assign bus.rom_ce         = 1'b1;
    assign bus.data_out_valid = valid;
    assign bus.data_out_last  = valid & mlast_q[rd_q];
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign bus.data_out[j] = mem_q[rd_q][PRECISION*j +: PRECISION];
    end
endmodule
